// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO blocks and their read-side helpers.
package fifo_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } rd_state_e;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry output FIFO; pops on valid & ready, push and pop may coincide.
module skid_buf2 #(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic                  pop;

  assign valid = (count_q != 2'd0);
  assign data  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign pop   = valid & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Reads a requested number of words from a FIFO and streams them downstream
// through a two-entry skid buffer with valid/ready flow control.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned BURST_W    = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  start,
  input  logic [BURST_W-1:0]    burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  rd_state_e          state_q, state_d;
  logic [BURST_W-1:0] len_q;
  logic [BURST_W-1:0] issued_q;
  logic               inflight_q;
  logic               done_q;
  logic [1:0]         occ;
  logic [1:0]         occ_net;
  logic               pop;
  logic               accept;
  logic               last_issue;
  logic               drained;

  // Occupancy is counted net of this cycle's pop so steady streaming keeps 1 word/cycle.
  assign pop        = out_valid & out_ready;
  assign occ_net    = occ - {1'b0, pop};
  assign drained    = !inflight_q && (occ_net == 2'd0);
  assign accept     = (state_q == StIdle) && start && (burst_len != '0);
  assign last_issue = rd_en && ((issued_q + BURST_W'(1)) == len_q);

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last_issue) state_d = StFlush;
      StFlush: if (drained) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_en = (state_q == StRun) && !empty && (issued_q < len_q) &&
            (({1'b0, inflight_q} + occ_net) < 2'd2);
    busy  = (state_q != StIdle) || done_q;
    done  = done_q;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      done_q     <= ((state_q == StIdle) && start && (burst_len == '0)) ||
                    ((state_q == StFlush) && drained);
      if (accept) begin
        len_q    <= burst_len;
        issued_q <= '0;
      end else if (rd_en) begin
        issued_q <= issued_q + BURST_W'(1);
      end
    end
  end

  skid_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid_buf2 (
    .clk      (rd_clk),
    .rst_n    (rd_rst_n),
    .push     (inflight_q),
    .push_data(rd_data),
    .ready    (out_ready),
    .valid    (out_valid),
    .data     (out_data),
    .count    (occ)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO source plus a stream-order
// reference model of delivered words, done timing and busy.
module tb_fifo_burst_reader;

  localparam int DW = 4;
  localparam int BW = 4;

  logic          rd_clk;
  logic          rd_rst_n;
  logic          start;
  logic [BW-1:0] burst_len;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  fifo_burst_reader #(
    .DATA_WIDTH(DW),
    .BURST_W   (BW)
  ) dut (
    .rd_clk   (rd_clk),
    .rd_rst_n (rd_rst_n),
    .start    (start),
    .burst_len(burst_len),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int n_checks = 0;
  int n_errors = 0;

  // FIFO source contents and the model's view of the not-yet-delivered word stream.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] model_stream[$];
  logic [DW-1:0] rd_word;
  logic          rd_pending = 1'b0;
  logic          hold_empty = 1'b0;
  logic          ready_val = 1'b1;
  logic          rand_mode = 1'b0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data;
  logic          active = 1'b0;
  int            exp_remaining = 0;
  int            done_due = -1;
  int            cyc = 0;
  int            first_hs = -1;
  int            last_hs = -1;
  int            n_reads = 0;
  int            n_hs = 0;
  int            n_done = 0;
  int            max_outstanding = 0;
  int            to_push = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    model_stream.push_back(w);
  endtask

  task automatic model_reset();
    active        = 1'b0;
    exp_remaining = 0;
    done_due      = -1;
    stall_prev    = 1'b0;
    rd_pending    = 1'b0;
    n_reads       = 0;
    n_hs          = 0;
    to_push       = 0;
    fifo_q.delete();
    model_stream.delete();
  endtask

  task automatic monitor();
    int outstanding;
    if (!rd_rst_n) return;
    check("rd_en_while_empty", {31'b0, rd_en & empty}, 32'd0);
    outstanding = n_reads - n_hs;
    if (outstanding > max_outstanding) max_outstanding = outstanding;
    check("buffer_bound", {31'b0, outstanding <= 2}, 32'd1);
    check("busy", {31'b0, busy}, {31'b0, active});
    if (out_valid && stall_prev) check("stall_stable", {28'b0, out_data}, {28'b0, stall_data});
    stall_prev = out_valid && !out_ready;
    stall_data = out_data;
    if (rd_en) begin
      n_reads++;
      if (fifo_q.size() == 0) check("fifo_underflow", fifo_q.size(), 32'd1);
      else begin
        rd_word    = fifo_q.pop_front();
        rd_pending = 1'b1;
      end
    end
    if (out_valid && out_ready) begin
      n_hs++;
      check("burst_remaining", {31'b0, exp_remaining != 0}, 32'd1);
      if (exp_remaining != 0 && model_stream.size() != 0) begin
        check("out_data", {28'b0, out_data}, {28'b0, model_stream.pop_front()});
        exp_remaining--;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (exp_remaining == 0) done_due = cyc + 1;
      end
    end
    if (done || cyc == done_due) begin
      check("done_pulse", {31'b0, done}, {31'b0, cyc == done_due});
      if (done) begin
        done_due = -1;
        active   = 1'b0;
        n_done++;
      end
    end
    if (start && !active) begin
      active   = 1'b1;
      first_hs = -1;
      if (burst_len == '0) done_due = cyc + 1;
      else exp_remaining = int'(burst_len);
    end
  endtask

  task automatic cycle();
    @(negedge rd_clk);
    if (rand_mode) begin
      out_ready  = ($urandom_range(3) != 0);
      hold_empty = ($urandom_range(5) == 0);
    end else begin
      out_ready = ready_val;
    end
    empty = hold_empty || (fifo_q.size() == 0);
    #1;
    cyc++;
    monitor();
    @(posedge rd_clk);
    #1;
    rd_data    = rd_pending ? rd_word : DW'($urandom);
    rd_pending = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0;
    d0 = n_done;
    for (int i = 0; i < budget && n_done == d0; i++) begin
      if (to_push > 0 && $urandom_range(1) == 1) begin
        push_word(DW'($urandom));
        to_push--;
      end
      if (rand_mode && exp_remaining > 1 && $urandom_range(7) == 0) begin
        start     = 1'b1;
        burst_len = BW'($urandom);
      end
      cycle();
      start = 1'b0;
    end
    check(tag, n_done - d0, 32'd1);
  endtask

  task automatic kick(input int len);
    start     = 1'b1;
    burst_len = BW'(len);
    cycle();
    start     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, {31'b0, rd_en}, 32'd0);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_out_data"}, {28'b0, out_data}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int h0;
    int r0;
    int len;
    int pre;
    rd_rst_n  = 1'b0;
    start     = 1'b0;
    burst_len = '0;
    rd_data   = '0;
    empty     = 1'b1;
    out_ready = 1'b0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge rd_clk);
    #1;
    rd_rst_n = 1'b1;

    // Preloaded burst at full throughput.
    push_word(4'd13); push_word(4'd14); push_word(4'd15); push_word(4'd0);
    h0 = n_hs;
    kick(4);
    wait_done(30, "s1_done");
    check("s1_count", n_hs - h0, 32'd4);
    check("s1_consecutive", last_hs - first_hs, 32'd3);
    check("s1_busy_after_done", {31'b0, busy}, 32'd0);

    // Source runs dry, refills, runs dry again.
    h0 = n_hs;
    r0 = n_reads;
    kick(4);
    repeat (4) cycle();
    check("s2_no_read_while_empty", n_reads - r0, 32'd0);
    push_word(4'd3); push_word(4'd9);
    repeat (6) cycle();
    check("s2_partial", n_hs - h0, 32'd2);
    repeat (5) cycle();
    check("s2_hold", n_hs - h0, 32'd2);
    push_word(4'd7); push_word(4'd1);
    wait_done(30, "s2_done");
    check("s2_count", n_hs - h0, 32'd4);

    // Downstream stall mid-burst.
    for (int i = 0; i < 6; i++) push_word(DW'(i + 5));
    h0 = n_hs;
    max_outstanding = 0;
    kick(6);
    repeat (3) cycle();
    ready_val = 1'b0;
    repeat (4) cycle();
    ready_val = 1'b1;
    wait_done(30, "s3_done");
    check("s3_count", n_hs - h0, 32'd6);
    check("s3_max_buffered", max_outstanding, 32'd2);

    // Zero-length request.
    r0 = n_reads;
    kick(0);
    wait_done(5, "s4_done");
    check("s4_no_read", n_reads - r0, 32'd0);

    // Second start during RUN must not relatch the length.
    push_word(4'd2); push_word(4'd4); push_word(4'd6);
    h0 = n_hs;
    kick(3);
    kick(9);
    wait_done(30, "s5_done");
    check("s5_count", n_hs - h0, 32'd3);

    // Maximum burst length.
    for (int i = 0; i < 15; i++) push_word(DW'($urandom));
    h0 = n_hs;
    kick(15);
    wait_done(60, "max_done");
    check("max_count", n_hs - h0, 32'd15);
    check("max_throughput", last_hs - first_hs, 32'd14);

    // Reset mid-burst, then a fresh burst.
    for (int i = 0; i < 8; i++) push_word(DW'(i + 8));
    h0 = n_hs;
    kick(8);
    for (int i = 0; i < 20 && (n_hs - h0) < 2; i++) cycle();
    check("s6_two_words", n_hs - h0, 32'd2);
    rd_rst_n = 1'b0;
    #1;
    check_reset_outputs("s6_reset");
    model_reset();
    repeat (2) cycle();
    rd_rst_n = 1'b1;
    repeat (4) cycle();
    check("s6_no_done", n_done, n_done - 0);
    push_word(4'd10); push_word(4'd11);
    h0 = n_hs;
    kick(2);
    wait_done(30, "s6_fresh_done");
    check("s6_fresh_count", n_hs - h0, 32'd2);

    // Randomized bursts with random backpressure, source gaps and stray starts.
    rand_mode = 1'b1;
    for (int b = 0; b < 25; b++) begin
      len = $urandom_range(15);
      pre = $urandom_range(len);
      for (int i = 0; i < pre; i++) push_word(DW'($urandom));
      to_push = len - pre;
      h0 = n_hs;
      kick(len);
      wait_done(300, "rand_done");
      check("rand_count", n_hs - h0, len);
      check("rand_fifo_drained", fifo_q.size() + to_push, 32'd0);
    end
    rand_mode = 1'b0;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, giving the width of FIFO read data and output data.
REQ-002 SHALL have parameter BURST_W, default 4, giving the width of the burst-length request.
REQ-003 SHALL have port rd_clk, input, 1 bit: single clock, the FIFO read-domain clock.
REQ-004 SHALL have port rd_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: one-cycle burst request.
REQ-006 SHALL have port burst_len, input, BURST_W bits: number of words to read, sampled with start.
REQ-007 SHALL have port busy, output, 1 bit: high from accepted start until the done cycle, inclusive.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the burst is fully delivered.
REQ-009 SHALL have port rd_en, output, 1 bit: FIFO read enable.
REQ-010 SHALL have port rd_data, input, DATA_WIDTH bits: FIFO read data, valid one rd_clk cycle after rd_en sampled high.
REQ-011 SHALL have port empty, input, 1 bit: FIFO empty flag.
REQ-012 SHALL have port out_valid, output, 1 bit: downstream data valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream ready.
REQ-014 SHALL have port out_data, output, DATA_WIDTH bits: downstream data.

Function
REQ-015 SHALL implement the states IDLE, RUN and FLUSH.
REQ-016 SHALL, in IDLE with start=1 and burst_len!=0, latch burst_len, clear the issue counter and enter RUN next cycle; start SHALL be ignored outside IDLE.
REQ-017 SHALL, on start with burst_len=0, pulse done the next cycle and remain in IDLE, with no rd_en.
REQ-018 SHALL drive rd_en=1 only when state=RUN, empty=0, issued<len and (words in flight + buffer occupancy) < 2; rd_en SHALL never be high while empty=1.
REQ-019 SHALL increment the issue counter on each rd_en cycle and move RUN to FLUSH in the cycle after the last read issues.
REQ-020 SHALL capture rd_data into a 2-entry output FIFO (skid buffer) one cycle after each rd_en, with no word dropped or duplicated.
REQ-021 SHALL present out_valid = buffer non-empty and out_data = buffer head, and SHALL pop one entry per cycle where out_valid and out_ready are both high.
REQ-022 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-023 SHALL leave FLUSH for IDLE, asserting done for one cycle, when no read is in flight and the buffer is empty after the last accepted handshake.
REQ-024 SHALL deliver words in FIFO order, with back-to-back throughput of 1 word/cycle when empty=0 and out_ready=1.
REQ-025 SHALL handle capture and pop in the same cycle without changing occupancy.
REQ-026 SHALL wrap the issue counter at BURST_W bits; burst_len = 2^BURST_W-1 is the maximum burst.

Reset
REQ-027 SHALL, with rd_rst_n=0, asynchronously force state=IDLE, counters=0, buffer empty, rd_en=0, out_valid=0, out_data=0, busy=0 and done=0.
REQ-028 SHALL, on reset mid-burst, discard in-flight and buffered words and SHALL NOT emit done.

Structure
REQ-029 SHALL take the state encodings (IDLE=0, RUN=1, FLUSH=2) from a shared package fifo_pkg, which the async FIFO blocks also use.
REQ-030 SHALL implement the 2-entry output buffer as sub-module skid_buf2, parameterised by DATA_WIDTH.

Verification
REQ-031 SHALL be verified with this scenario: FIFO preloaded with 13,14,15,0; start with len=4; out_ready=1 -> out_data 13,14,15,0 on 4 consecutive cycles, done 1 cycle after the last word, busy low after done.
REQ-032 SHALL be verified with this scenario: len=4, FIFO empty until 2 words are written, then empty for 5 cycles -> rd_en=0 whenever empty=1, burst resumes, and exactly 4 words are delivered.
REQ-033 SHALL be verified with this scenario: len=6, out_ready held low for 4 cycles mid-burst -> at most 2 words buffered, out_data stable during the stall, no loss or duplication.
REQ-034 SHALL be verified with this scenario: start with len=0 -> done the next cycle, rd_en never high.
REQ-035 SHALL be verified with this scenario: start pulsed again during RUN -> ignored, the burst count stays as originally latched.
REQ-036 SHALL be verified with this scenario: rd_rst_n low after 2 words of a len=8 burst -> all outputs 0 immediately, IDLE, no done; a fresh len=2 burst then completes normally.
